// File: rtl/sensor_report_arbiter_if.sv
// UART frame port shared by the sensor reporters: frame data, strobe and
// transmitter back-pressure.
interface sensor_report_arbiter_if;
    logic [47:0] tx_data;
    logic        tx_de;
    logic        uart_busy;

    modport master (output tx_data, output tx_de, input uart_busy);
    modport slave  (input tx_data, input tx_de, output uart_busy);
endinterface

// File: rtl/sensor_report_arbiter.sv
// Arbitrates fire / DHT11 / I2C reports onto one 48-bit UART frame port,
// with one-deep holding buffers and a minimum inter-frame gap.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | waiting for any pending buffer; grants and strobes a frame
//  ST_GAP  | counting down the inter-frame gap, then waiting for the UART
module sensor_report_arbiter #(
    parameter int GAP_CYCLES = 100
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fire_detect,
    input  logic                           dht_valid,
    input  logic [7:0]                     dht_temp,
    input  logic [7:0]                     dht_humi,
    input  logic                           i2c_valid,
    input  logic [35:0]                    i2c_data,
    sensor_report_arbiter_if.master        tx,
    output logic                           busy,
    output logic [2:0]                     ovf
);

    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_GAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        fire_s1_q, fire_s1_d;
    logic        fire_s2_q, fire_s2_d;
    logic        fire_prev_q, fire_prev_d;
    logic        fire_ev_q, fire_ev_d;
    logic        fire_pend_q, fire_pend_d;
    logic        fire_pay_q, fire_pay_d;
    logic        dht_pend_q, dht_pend_d;
    logic [15:0] dht_pay_q, dht_pay_d;
    logic        i2c_pend_q, i2c_pend_d;
    logic [35:0] i2c_pay_q, i2c_pay_d;
    logic        last_q, last_d;
    logic [47:0] tx_data_q, tx_data_d;
    logic        tx_de_q, tx_de_d;
    logic        busy_q, busy_d;
    logic [2:0]  ovf_q, ovf_d;
    logic        gnt_fire, gnt_dht, gnt_i2c, any_gnt;

    always_comb begin
        fire_s1_d   = fire_detect;
        fire_s2_d   = fire_s1_q;
        fire_prev_d = fire_s2_q;
        fire_ev_d   = fire_s2_q ^ fire_prev_q;

        // last_q = 1 means I2C was the most recent of the DHT/I2C pair granted
        gnt_fire = 1'b0;
        gnt_dht  = 1'b0;
        gnt_i2c  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (fire_pend_q)
                gnt_fire = 1'b1;
            else if (dht_pend_q && (!i2c_pend_q || last_q))
                gnt_dht = 1'b1;
            else if (i2c_pend_q)
                gnt_i2c = 1'b1;
        end
        any_gnt = gnt_fire | gnt_dht | gnt_i2c;

        // A refill on the grant edge keeps pending set; the frame takes the old payload.
        fire_pend_d = fire_ev_q | (fire_pend_q & ~gnt_fire);
        fire_pay_d  = fire_ev_q ? ~fire_prev_q : fire_pay_q;
        dht_pend_d  = dht_valid | (dht_pend_q & ~gnt_dht);
        dht_pay_d   = dht_valid ? {dht_temp, dht_humi} : dht_pay_q;
        i2c_pend_d  = i2c_valid | (i2c_pend_q & ~gnt_i2c);
        i2c_pay_d   = i2c_valid ? i2c_data : i2c_pay_q;

        ovf_d = ovf_q | {i2c_valid & i2c_pend_q & ~gnt_i2c,
                         dht_valid & dht_pend_q & ~gnt_dht,
                         fire_ev_q & fire_pend_q & ~gnt_fire};

        last_d = gnt_dht ? 1'b0 : (gnt_i2c ? 1'b1 : last_q);

        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        tx_de_d   = 1'b0;
        tx_data_d = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (any_gnt) begin
                    state_d   = ST_GAP;
                    tx_de_d   = 1'b1;
                    gap_cnt_d = GAP_LOAD;
                    if (gnt_fire)
                        tx_data_d = {4'h1, 43'd0, fire_pay_q};
                    else if (gnt_dht)
                        tx_data_d = {4'h2, 28'd0, dht_pay_q};
                    else
                        tx_data_d = {4'h3, 8'd0, i2c_pay_q};
                end
            end
            ST_GAP: begin
                if (gap_cnt_q != 16'd0)
                    gap_cnt_d = gap_cnt_q - 16'd1;
                else if (!tx.uart_busy)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= 16'd0;
            fire_s1_q   <= 1'b1;
            fire_s2_q   <= 1'b1;
            fire_prev_q <= 1'b1;
            fire_ev_q   <= 1'b0;
            fire_pend_q <= 1'b0;
            fire_pay_q  <= 1'b0;
            dht_pend_q  <= 1'b0;
            dht_pay_q   <= 16'd0;
            i2c_pend_q  <= 1'b0;
            i2c_pay_q   <= 36'd0;
            last_q      <= 1'b1;
            tx_data_q   <= 48'd0;
            tx_de_q     <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            fire_s1_q   <= fire_s1_d;
            fire_s2_q   <= fire_s2_d;
            fire_prev_q <= fire_prev_d;
            fire_ev_q   <= fire_ev_d;
            fire_pend_q <= fire_pend_d;
            fire_pay_q  <= fire_pay_d;
            dht_pend_q  <= dht_pend_d;
            dht_pay_q   <= dht_pay_d;
            i2c_pend_q  <= i2c_pend_d;
            i2c_pay_q   <= i2c_pay_d;
            last_q      <= last_d;
            tx_data_q   <= tx_data_d;
            tx_de_q     <= tx_de_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign tx.tx_data = tx_data_q;
    assign tx.tx_de   = tx_de_q;
    assign busy       = busy_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_sensor_report_arbiter.sv
// Scoreboard bench for sensor_report_arbiter: stimulus pushes expected frames,
// a negedge monitor pops and compares them on every tx_de.
module tb_sensor_report_arbiter;

    localparam int G = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        fire_detect;
    logic        dht_valid;
    logic [7:0]  dht_temp;
    logic [7:0]  dht_humi;
    logic        i2c_valid;
    logic [35:0] i2c_data;
    logic        busy;
    logic [2:0]  ovf;

    sensor_report_arbiter_if tx_if ();

    sensor_report_arbiter #(.GAP_CYCLES(G)) dut (
        .clk         (clk),
        .rst         (rst),
        .fire_detect (fire_detect),
        .dht_valid   (dht_valid),
        .dht_temp    (dht_temp),
        .dht_humi    (dht_humi),
        .i2c_valid   (i2c_valid),
        .i2c_data    (i2c_data),
        .tx          (tx_if.master),
        .busy        (busy),
        .ovf         (ovf)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [47:0] data;
        int          abs_cyc;
        int          dt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   frames = 0;
    int   last_de_cyc = 0;
    logic prev_de = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_if.tx_de) begin
                exp_t e;
                frames++;
                chk("de_not_back_to_back", 64'(prev_de), 64'd0);
                chk("frame_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("tx_data", 64'(tx_if.tx_data), 64'(e.data));
                    if (e.abs_cyc >= 0)
                        chk("tx_de_cycle", 64'(cyc), 64'(e.abs_cyc));
                    if (e.dt > 0)
                        chk("frame_spacing", 64'(cyc - last_de_cyc), 64'(e.dt));
                end
                last_de_cyc = cyc;
            end
            prev_de = tx_if.tx_de;
        end else begin
            prev_de = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [47:0] d, input int a, input int dt);
        exp_t e;
        e.data    = d;
        e.abs_cyc = a;
        e.dt      = dt;
        exp_q.push_back(e);
    endtask

    task automatic pulse_dht(input logic [7:0] t, input logic [7:0] h);
        dht_temp  = t;
        dht_humi  = h;
        dht_valid = 1'b1;
        tick(1);
        dht_valid = 1'b0;
    endtask

    task automatic pulse_i2c(input logic [35:0] d);
        i2c_data  = d;
        i2c_valid = 1'b1;
        tick(1);
        i2c_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick(1);
            n++;
        end
        chk("drain_within_budget", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            tick(1);
            n++;
        end
        chk("idle_within_budget", 64'(busy), 64'd0);
    endtask

    initial begin
        int f0;
        rst         = 1'b1;
        fire_detect = 1'b1;
        dht_valid   = 1'b0;
        dht_temp    = 8'd0;
        dht_humi    = 8'd0;
        i2c_valid   = 1'b0;
        i2c_data    = 36'd0;
        tx_if.uart_busy = 1'b0;
        tick(3);
        chk("reset_tx_de", 64'(tx_if.tx_de), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk("reset_tx_data", 64'(tx_if.tx_data), 64'd0);
        rst = 1'b0;

        // single DHT sample
        tick(8);
        push(48'h2000_0000_193C, cyc + 2, 0);
        pulse_dht(8'h19, 8'h3C);
        wait_drain();
        chk("single_dht_ovf", 64'(ovf), 64'd0);
        wait_idle();

        // DHT and I2C tie right after a DHT grant: I2C wins
        push(48'h3000_1234_5678, cyc + 2, 0);
        push(48'h2000_0000_AA55, -1, G + 1);
        dht_temp = 8'hAA; dht_humi = 8'h55; i2c_data = 36'h0_1234_5678;
        dht_valid = 1'b1; i2c_valid = 1'b1;
        tick(1);
        dht_valid = 1'b0; i2c_valid = 1'b0;
        wait_drain();
        wait_idle();

        // I2C overwrite during a gap
        push(48'h2000_0000_0102, cyc + 2, 0);
        pulse_dht(8'h01, 8'h02);
        wait_drain();
        push(48'h3000_0000_0002, -1, G + 1);
        pulse_i2c(36'h1);
        tick(2);
        pulse_i2c(36'h2);
        wait_drain();
        chk("overwrite_ovf", 64'(ovf), 64'b100);
        wait_idle();

        // DHT refill on the exact grant edge
        push(48'h2000_0000_1122, cyc + 2, 0);
        push(48'h2000_0000_3344, -1, G + 1);
        pulse_dht(8'h11, 8'h22);
        pulse_dht(8'h33, 8'h44);
        wait_drain();
        chk("refill_ovf", 64'(ovf), 64'b100);
        wait_idle();

        // UART busy stretches the gap
        push(48'h2000_0000_5566, cyc + 2, 0);
        pulse_dht(8'h55, 8'h66);
        wait_drain();
        tx_if.uart_busy = 1'b1;
        pulse_i2c(36'h9_ABCD_EF01);
        tick(150);
        chk("stretch_busy", 64'(busy), 64'd1);
        chk("stretch_no_de", 64'(tx_if.tx_de), 64'd0);
        tick(150);
        tx_if.uart_busy = 1'b0;
        push(48'h3009_ABCD_EF01, cyc + 2, 0);
        wait_drain();
        wait_idle();

        // reset mid-gap with a DHT pending
        push(48'h2000_0000_7788, cyc + 2, 0);
        pulse_dht(8'h77, 8'h88);
        wait_drain();
        pulse_dht(8'h99, 8'hAA);
        tick(5);
        rst = 1'b1;
        tick(1);
        chk("midrst_tx_de", 64'(tx_if.tx_de), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ovf", 64'(ovf), 64'd0);
        tick(2);
        rst = 1'b0;
        f0 = frames;
        tick(300);
        chk("no_frame_after_reset", 64'(frames - f0), 64'd0);
        chk("idle_after_reset", 64'(busy), 64'd0);

        // fire fall with DHT and I2C pending on the same edge
        fire_detect = 1'b0;
        tick(3);
        push(48'h1000_0000_0001, cyc + 2, 0);
        push(48'h2000_0000_CCDD, -1, G + 1);
        push(48'h3000_1234_5678, -1, G + 1);
        dht_temp = 8'hCC; dht_humi = 8'hDD; i2c_data = 36'h0_1234_5678;
        dht_valid = 1'b1; i2c_valid = 1'b1;
        tick(1);
        dht_valid = 1'b0; i2c_valid = 1'b0;
        wait_drain();
        chk("priority_ovf", 64'(ovf), 64'd0);
        wait_idle();

        // fire rise: level payload 0
        push(48'h1000_0000_0000, cyc + 5, 0);
        fire_detect = 1'b1;
        wait_drain();
        wait_idle();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
